// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and encodings for the multicycle controller and main decoder
//
// Contents:
//   state_t     multicycle sequencer states (encoding is visible on state_o)
//   op_class_t  instruction class produced by main_decoder
//   OP_*        7-bit major opcodes
//   ALUOP_*     2-bit ALU operation class handed to the ALU decoder
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_R    = 4'd0,
        CLS_I    = 4'd1,
        CLS_U    = 4'd2,
        CLS_LW   = 4'd3,
        CLS_SW   = 4'd4,
        CLS_BR   = 4'd5,
        CLS_JALR = 4'd6,
        CLS_JAL  = 4'd7,
        CLS_ILL  = 4'd8
    } op_class_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD = 2'b00;  // LW/SW/JALR/JAL address or link
    localparam logic [1:0] ALUOP_BR  = 2'b01;  // branch compare
    localparam logic [1:0] ALUOP_RI  = 2'b10;  // funct-decoded R/I operations
    localparam logic [1:0] ALUOP_LUI = 2'b11;  // pass upper immediate

    // Classes that end in EXEC by redirecting the PC.
    function automatic logic is_flow(input op_class_t cls);
        return (cls == CLS_BR) || (cls == CLS_JALR) || (cls == CLS_JAL);
    endfunction

    // Classes that write a link register in EXEC.
    function automatic logic is_link(input op_class_t cls);
        return (cls == CLS_JALR) || (cls == CLS_JAL);
    endfunction

endpackage

// File: rtl/multicycle_controller_main_decoder.sv
// rtl/multicycle_controller_main_decoder.sv - combinational opcode to datapath-control decoder
//
// Shared between the single-cycle path and the multicycle controller.
// Ports:
//   op_i          in   7  major opcode
//   cls_o         out  4  instruction class (CLS_ILL when not legal)
//   legal_o       out  1  opcode is supported
//   alu_src_o     out  1  ALU B operand from immediate
//   alu_op_o      out  2  ALU operation class
//   mem_to_reg_o  out  1  write-back data from memory
//   branch_o      out  1  conditional branch
//   jalr_sel_o    out  1  register-indirect jump
//   jal_sel_o     out  1  PC-relative jump
// Parameter ENABLE_JAL: when 0, the JAL opcode decodes as illegal.
module main_decoder
    import ctrl_pkg::*;
#(
    parameter bit ENABLE_JAL = 1'b1
) (
    input  logic [6:0] op_i,
    output op_class_t  cls_o,
    output logic       legal_o,
    output logic       alu_src_o,
    output logic [1:0] alu_op_o,
    output logic       mem_to_reg_o,
    output logic       branch_o,
    output logic       jalr_sel_o,
    output logic       jal_sel_o
);

    always_comb begin
        cls_o        = CLS_ILL;
        legal_o      = 1'b0;
        alu_src_o    = 1'b0;
        alu_op_o     = ALUOP_ADD;
        mem_to_reg_o = 1'b0;
        branch_o     = 1'b0;
        jalr_sel_o   = 1'b0;
        jal_sel_o    = 1'b0;

        case (op_i)
            OP_R: begin
                cls_o    = CLS_R;
                legal_o  = 1'b1;
                alu_op_o = ALUOP_RI;
            end
            OP_I: begin
                cls_o     = CLS_I;
                legal_o   = 1'b1;
                alu_src_o = 1'b1;
                alu_op_o  = ALUOP_RI;
            end
            OP_LUI: begin
                cls_o     = CLS_U;
                legal_o   = 1'b1;
                alu_src_o = 1'b1;
                alu_op_o  = ALUOP_LUI;
            end
            OP_LW: begin
                cls_o        = CLS_LW;
                legal_o      = 1'b1;
                alu_src_o    = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            OP_SW: begin
                cls_o     = CLS_SW;
                legal_o   = 1'b1;
                alu_src_o = 1'b1;
            end
            OP_BR: begin
                cls_o    = CLS_BR;
                legal_o  = 1'b1;
                alu_op_o = ALUOP_BR;
                branch_o = 1'b1;
            end
            OP_JALR: begin
                cls_o      = CLS_JALR;
                legal_o    = 1'b1;
                alu_src_o  = 1'b1;
                jalr_sel_o = 1'b1;
            end
            OP_JAL: begin
                if (ENABLE_JAL) begin
                    cls_o     = CLS_JAL;
                    legal_o   = 1'b1;
                    jal_sel_o = 1'b1;
                end
            end
            default: begin
                cls_o   = CLS_ILL;
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle FETCH/DECODE/EXEC/MEM/WB instruction sequencer
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   Opcode                instr[6:0], captured into op_q on the IRWrite cycle
//   stall                 freeze state/op_q/wait counter and mask write strobes
//   imem_ready            instruction memory data valid
//   dmem_ready            data memory read valid / write accepted
//   imem_req              fetch request, held until imem_ready
//   IRWrite, PCWrite      IR load / PC update strobes
//   ALUSrc .. JalSel      decoded datapath controls, valid DECODE..end of instruction
//   RegWrite, MemRead, MemWrite
//   ALUOp                 ALU operation class
//   illegal, timeout      sticky trap causes
//   state_o               current state encoding
// Parameters:
//   TIMEOUT_CYCLES        max ready-low wait cycles in FETCH/MEM before trapping (>=1)
//   ENABLE_JAL            JAL opcode legal when 1
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          ENABLE_JAL     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Opcode,
    input  logic       stall,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       Branch,
    output logic       JalrSel,
    output logic       JalSel,
    output logic [1:0] ALUOp,
    output logic       illegal,
    output logic       timeout,
    output logic [2:0] state_o
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [6:0]    op_q, op_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          illegal_q, illegal_d;
    logic          timeout_q, timeout_d;

    op_class_t     cls;
    logic          legal;
    logic          dec_alu_src;
    logic [1:0]    dec_alu_op;
    logic          dec_mem_to_reg;
    logic          dec_branch;
    logic          dec_jalr_sel;
    logic          dec_jal_sel;

    // Decode only the registered opcode so every control is a function of
    // state and op_q; the raw Opcode bus may change once IR is loaded.
    main_decoder #(
        .ENABLE_JAL (ENABLE_JAL)
    ) u_main_decoder (
        .op_i         (op_q),
        .cls_o        (cls),
        .legal_o      (legal),
        .alu_src_o    (dec_alu_src),
        .alu_op_o     (dec_alu_op),
        .mem_to_reg_o (dec_mem_to_reg),
        .branch_o     (dec_branch),
        .jalr_sel_o   (dec_jalr_sel),
        .jal_sel_o    (dec_jal_sel)
    );

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wait_cnt_d = wait_cnt_q;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;

        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    op_d    = Opcode;
                    state_d = DECODE;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = TRAP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            DECODE: begin
                if (legal) begin
                    state_d = EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = TRAP;
                end
            end
            EXEC: begin
                if (is_flow(cls)) begin
                    state_d = FETCH;
                end else if ((cls == CLS_LW) || (cls == CLS_SW)) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                if (dmem_ready) begin
                    state_d = (cls == CLS_LW) ? WB : FETCH;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = TRAP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            WB: begin
                state_d = FETCH;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = TRAP;
            end
        endcase

        // The wait budget is per handshake, so any transition starts it afresh.
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end
    end

    // State register; reset wins over stall, stall freezes everything else.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            op_q       <= '0;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else if (!stall) begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    // Output decode. Outputs are forced low during reset so the datapath
    // sees no request or strobe before the sequencer is initialised.
    // Write strobes are masked by stall; request levels are not, so a
    // pending memory access stays visible to the memory while frozen.
    logic in_instr;
    logic wr_ok;

    always_comb begin
        imem_req = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Branch   = 1'b0;
        JalrSel  = 1'b0;
        JalSel   = 1'b0;
        ALUOp    = 2'b00;
        illegal  = 1'b0;
        timeout  = 1'b0;
        state_o  = 3'd0;
        in_instr = 1'b0;
        wr_ok    = 1'b0;

        if (rst_n) begin
            wr_ok    = !stall;
            in_instr = (state_q == DECODE) || (state_q == EXEC) ||
                       (state_q == MEM)    || (state_q == WB);

            if (in_instr) begin
                ALUSrc   = dec_alu_src;
                ALUOp    = dec_alu_op;
                MemtoReg = dec_mem_to_reg;
                Branch   = dec_branch;
                JalrSel  = dec_jalr_sel;
                JalSel   = dec_jal_sel;
            end

            case (state_q)
                FETCH: begin
                    imem_req = 1'b1;
                    IRWrite  = imem_ready && wr_ok;
                end
                EXEC: begin
                    PCWrite  = is_flow(cls) && wr_ok;
                    RegWrite = is_link(cls) && wr_ok;
                end
                MEM: begin
                    MemRead  = (cls == CLS_LW);
                    MemWrite = (cls == CLS_SW) && wr_ok;
                    // A store retires in MEM, so it updates the PC on accept.
                    PCWrite  = (cls == CLS_SW) && dmem_ready && wr_ok;
                end
                WB: begin
                    RegWrite = wr_ok;
                    PCWrite  = wr_ok;
                end
                default: begin
                end
            endcase

            illegal = illegal_q;
            timeout = timeout_q;
            state_o = state_q;
        end
    end

endmodule
